// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode constants and index-width helper for stream_mux_rr
package stream_mux_pkg;

  // Mode input encoding
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Width of a channel index; never less than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - select / round-robin grant logic for stream_mux_rr
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  input  logic [IW-1:0] sel,
  output logic [IW-1:0] grant,
  output logic          grant_valid
);

  // Pick the granted channel; the round-robin search runs from the farthest
  // candidate back to ptr so the last hit is the first channel at or after ptr
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (mode == MODE_SEL) begin
      // An out-of-range select index never grants
      if (int'(sel) < N) begin
        grant       = sel;
        grant_valid = req[sel];
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N;
        if (req[idx[IW-1:0]]) begin
          grant       = idx[IW-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-to-1 stream mux with select/round-robin arbitration; STREAM_MUX_CNT_EN adds xfer_cnt
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int IW    = idx_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [IW-1:0]      sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [15:0]        xfer_cnt
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant;
  logic             grant_valid;
  logic             load;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr_q),
    .mode        (mode),
    .sel         (sel),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Output register next state: load when empty or draining, so a drain and a
  // load in the same cycle keep one word per cycle; reset blocks any transfer
  always_comb begin
    load        = !out_valid_q || out_ready;
    xfer        = load && grant_valid && !rst;
    in_ready    = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      in_ready[grant] = 1'b1;
      out_data_d      = in_data[int'(grant)*WIDTH +: WIDTH];
      out_valid_d     = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = (int'(grant) == N - 1) ? '0 : grant + IW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef STREAM_MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count output handshakes, wrapping naturally at 16 bits
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready) cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - scoreboard bench for stream_mux_rr (N=4 and N=3 instances)
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef STREAM_MUX_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt3;
`endif

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ch_data [4] = '{8'h10, 8'h21, 8'hA5, 8'h3C};

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .N(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef STREAM_MUX_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  stream_mux_rr #(.WIDTH(8), .N(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(sel3), .mode(mode3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef STREAM_MUX_CNT_EN
    , .xfer_cnt(xfer_cnt3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus on the N=4 instance; expected in_ready checked at negedge
  task automatic drive(input logic m, input logic [1:0] s, input logic [3:0] v,
                       input logic ordy, input logic [3:0] exp_rdy, input logic [7:0] exp_data);
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    @(negedge clk);
    check("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'd0) exp_q.push_back(exp_data);
    @(posedge clk); #1;
  endtask

  // Monitor: every output handshake pops and compares the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", out_data);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  localparam int CNT_LOOP =
`ifdef STREAM_MUX_CNT_EN
    65536;
`else
    8;
`endif

  initial begin
    in_data  = {8'h3C, 8'hA5, 8'h21, 8'h10};
    in_data3 = {8'h33, 8'h22, 8'h11};
    rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_in_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 4'h0;

    // N=3: sel=3 is out of range, then sel=2 is granted
    @(negedge clk);
    check("n3_sel3_ready", {29'd0, in_ready3}, 32'd0);
    @(posedge clk); #1;
    check("n3_sel3_valid", {31'd0, out_valid3}, 32'd0);
    sel3 = 2'd2;
    @(negedge clk);
    check("n3_sel2_ready", {29'd0, in_ready3}, 32'h4);
    @(posedge clk); #1;
    check("n3_sel2_valid", {31'd0, out_valid3}, 32'd1);
    check("n3_sel2_data", {24'd0, out_data3}, 32'h33);
    sel3 = 2'd3;

    // Select mode, sel=2
    drive(1'b0, 2'd2, 4'b0110, 1'b1, 4'b0100, 8'hA5);
    check("sel_out_valid", {31'd0, out_valid}, 32'd1);
    check("sel_out_data", {24'd0, out_data}, 32'hA5);
    // Selected channel not valid: no grant
    drive(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 8'h00);
    drive(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'h00);
    check("drained_valid", {31'd0, out_valid}, 32'd0);

    // Round robin, all valid: 0,1,2,3,0
    for (int i = 0; i < 5; i++)
      drive(1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (i % 4)), ch_data[i % 4]);
    drive(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 8'h00);

    // ptr=1, only channel 3 valid -> grant 3 and ptr wraps to 0
    drive(1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 8'h3C);
    drive(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 8'h10);

    // Stall 3 cycles while FULL
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 8'h00);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {24'd0, out_data}, 32'h10);
    end
    // Release: drain of 0x10 and load of channel 1 in one cycle
    drive(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 8'h21);
    check("reload_valid", {31'd0, out_valid}, 32'd1);
    check("reload_data", {24'd0, out_data}, 32'h21);
    drive(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 8'h00);
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Select mode leaves ptr (=2) untouched; back in RR channel 2 wins
    drive(1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 8'h10);
    drive(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 8'hA5);

    // Reset while FULL discards the word and the pointer
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_data", {24'd0, out_data}, 32'd0);
`ifdef STREAM_MUX_CNT_EN
    check("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
    exp_q.delete();
    rst = 1'b0;

    // Stream from ptr=0; with the counter, 65536 handshakes wrap it to 0
    for (int i = 0; i < CNT_LOOP; i++)
      drive(1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (i % 4)), ch_data[i % 4]);
    drive(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 8'h00);
`ifdef STREAM_MUX_CNT_EN
    check("cnt_wrap", {16'd0, xfer_cnt}, 32'd0);
`endif
    drive(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, 8'h00);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits per channel.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  N  per-channel data valid.
REQ-007 in_ready  output  N  per-channel accept; a transfer occurs when in_valid[i] and in_ready[i] are both high.
REQ-008 sel  input  clog2(N)  channel index used in select mode.
REQ-009 mode  input  1  0 = select mode, 1 = round-robin mode.
REQ-010 out_data  output  WIDTH  registered output data.
REQ-011 out_valid  output  1  output register holds data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 Output stage is a single register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 load = !out_valid || out_ready; arbitration is evaluated combinationally every cycle.
REQ-015 Select mode: grant = sel, and the grant is active only if sel < N and in_valid[sel] = 1.
REQ-016 Round-robin mode: grant = the first channel with in_valid set, searching from rr_ptr upward and wrapping modulo N.
REQ-017 in_ready[i] = load && grant active && grant == i; at most one in_ready bit is high per cycle.
REQ-018 On a transfer, out_data <= in_data[grant] and out_valid <= 1, one cycle of latency.
REQ-019 When out_valid && out_ready and there is no new transfer, out_valid <= 0.
REQ-020 Simultaneous drain and load in one cycle sustain full throughput of one word per cycle with no bubble.
REQ-021 rr_ptr <= (grant+1) mod N only on a transfer in round-robin mode; otherwise rr_ptr holds.
REQ-022 A mode change takes effect in the same cycle; rr_ptr is preserved across mode changes.
REQ-023 While out_valid=1 && out_ready=0, out_data and out_valid are stable and all in_ready bits are 0.
REQ-024 No transfer occurs when no channel is valid; the output state is unaffected except by a drain.

Reset
REQ-025 While rst=1: out_valid=0, out_data=0, rr_ptr=0, in_ready=0, and the transfer counter is 0.
REQ-026 A reset asserted mid-stream discards the held word; no transfer completes in the reset cycle.

Configuration
REQ-027 Macro STREAM_MUX_CNT_EN defined: adds output xfer_cnt[15:0], which increments on every output handshake (out_valid && out_ready) and wraps from 0xFFFF to 0x0000.
REQ-028 Macro undefined: the xfer_cnt port and its counter do not exist; all other behaviour is identical.

Structure
REQ-029 Package stream_mux_pkg holds the mode constants MODE_SEL=1'b0 and MODE_RR=1'b1, plus a clog2-based index-width helper.
REQ-030 Sub-module rr_arbiter (inputs: req[N], ptr, mode, sel; outputs: grant index, grant_valid) holds all grant logic; stream_mux_rr holds the output register, rr_ptr and the counter.

Verification
REQ-031 N=4; mode=0, sel=2, in_valid=4'b0110, data2=0xA5, out_ready=1 -> in_ready=4'b0100, and out_data=0xA5 with out_valid=1 on the next cycle.
REQ-032 mode=1, all four channels valid continuously, out_ready=1 -> grant sequence 0,1,2,3,0, one word per cycle.
REQ-033 mode=1, only channel 3 valid, rr_ptr=1 -> channel 3 granted and rr_ptr becomes 0 (wrap).
REQ-034 out_valid=1 with out_ready=0 held for 3 cycles -> in_ready=0 and out_data stable; releasing out_ready gives a drain plus a new load in the same cycle.
REQ-035 N=3, mode=0, sel=3 -> no grant, in_ready=0, no transfer.
REQ-036 rst pulsed while FULL -> next cycle out_valid=0 and rr_ptr=0; with STREAM_MUX_CNT_EN, 65536 handshakes return xfer_cnt to 0.
